// File: rtl/fp16_mul_seq.sv
// Multi-cycle IEEE-754 binary16 multiplier: radix-2 shift-add mantissa product over
// 11 cycles, then one normalise/round cycle (RNE, subnormal in/out, canonical QNAN).
module fp16_mul_seq #(
   parameter logic [15:0] QNAN = 16'h7E00,
   parameter bit          FTZ  = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] y,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

   state_t             state, state_nx;
   logic [3:0]         cnt;
   logic [21:0]        acc;
   logic [10:0]        ma, mb;
   logic signed [8:0]  exp_r;
   logic               sgn;

   logic [4:0]         ea, eb, ea_eff, eb_eff;
   logic [9:0]         fa, fb;
   logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn_in;
   logic               sp_hit;
   logic [15:0]        sp_y;
   logic [10:0]        ma_raw, mb_raw;
   logic [3:0]         sha, shb;
   logic signed [8:0]  exp_in;

   function automatic logic [3:0] lzc11(input logic [10:0] v);
      logic [3:0] n;
      logic       hit;
      n   = 4'd0;
      hit = 1'b0;
      for (int i = 10; i >= 0; i--) begin
         if (!hit && !v[i]) n = n + 4'd1;
         if (v[i]) hit = 1'b1;
      end
      return n;
   endfunction

   // Product p has its unit bit at position 20 (value in [1,4)); e is the biased exponent of that unit.
   function automatic logic [15:0] round_pack(input logic s, input logic signed [8:0] e_in,
                                              input logic [21:0] p);
      logic signed [8:0] e;
      logic [20:0]       m;
      logic              st, g, sticky, inc;
      logic [8:0]        sh;
      logic [10:0]       mant;
      logic [11:0]       r;
      e = e_in;
      if (p[21]) begin
         m  = p[21:1];
         st = p[0];
         e  = e + 9'sd1;
      end else begin
         m  = p[20:0];
         st = 1'b0;
      end
      // Subnormal: denormalise to the scale of exponent field 1; the field reads 0 unless rounding restores the hidden bit.
      if (e <= 9'sd0) begin
         sh = 9'sd1 - e;
         if (sh >= 9'd24) begin
            st = st | (|m);
            m  = '0;
         end else begin
            st = st | (|(m & ((21'd1 << sh) - 21'd1)));
            m  = m >> sh;
         end
         e = 9'sd1;
      end
      mant   = m[20:10];
      g      = m[9];
      sticky = st | (|m[8:0]);
      inc    = g & (sticky | mant[0]);
      r      = {1'b0, mant} + {11'd0, inc};
      if (r[11]) begin
         r = r >> 1;
         e = e + 9'sd1;
      end
      if (e >= 9'sd31) return {s, 5'h1F, 10'd0};
      if (!r[10]) begin
         if (FTZ || (r[9:0] == 10'd0)) return {s, 15'd0};
         return {s, 5'd0, r[9:0]};
      end
      return {s, e[4:0], r[9:0]};
   endfunction

   assign ea     = a[14:10];
   assign eb     = b[14:10];
   assign fa     = a[9:0];
   assign fb     = b[9:0];
   assign sgn_in = a[15] ^ b[15];
   assign a_nan  = (ea == 5'h1F) && (fa != 10'd0);
   assign b_nan  = (eb == 5'h1F) && (fb != 10'd0);
   assign a_inf  = (ea == 5'h1F) && (fa == 10'd0);
   assign b_inf  = (eb == 5'h1F) && (fb == 10'd0);
   assign a_zero = (ea == 5'd0) && (fa == 10'd0);
   assign b_zero = (eb == 5'd0) && (fb == 10'd0);

   always_comb begin
      sp_hit = 1'b1;
      sp_y   = QNAN;
      if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) sp_y = QNAN;
      else if (a_inf || b_inf)                                     sp_y = {sgn_in, 5'h1F, 10'd0};
      else if (a_zero || b_zero)                                   sp_y = {sgn_in, 15'd0};
      else                                                         sp_hit = 1'b0;
   end

   assign ma_raw = {ea != 5'd0, fa};
   assign mb_raw = {eb != 5'd0, fb};
   assign sha    = lzc11(ma_raw);
   assign shb    = lzc11(mb_raw);
   assign ea_eff = (ea == 5'd0) ? 5'd1 : ea;
   assign eb_eff = (eb == 5'd0) ? 5'd1 : eb;
   assign exp_in = $signed({4'd0, ea_eff}) + $signed({4'd0, eb_eff}) - 9'sd15
                   - $signed({5'd0, sha}) - $signed({5'd0, shb});

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (in_valid) state_nx = sp_hit ? DONE : MUL;
         MUL:  if (cnt == 4'd10) state_nx = NORM;
         NORM: state_nx = DONE;
         DONE: if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 4'd0;
         y     <= 16'h0000;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (in_valid) begin
               cnt <= 4'd0;
               if (sp_hit) y <= sp_y;
            end
            MUL:  cnt <= cnt + 4'd1;
            NORM: y <= round_pack(sgn, exp_r, acc);
            default: ;
         endcase
      end
   end

   // Operand/accumulator datapath carries no reset; an aborted product is simply overwritten.
   always_ff @(posedge clk) begin
      if (state == IDLE && in_valid) begin
         sgn   <= sgn_in;
         ma    <= ma_raw << sha;
         mb    <= mb_raw << shb;
         exp_r <= exp_in;
         acc   <= '0;
      end else if (state == MUL && mb[cnt]) begin
         acc <= acc + ({11'd0, ma} << cnt);
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fp16_mul_seq.sv
// Directed bench for fp16_mul_seq: scoreboard of expected products checked at each
// result handshake, plus latency, backpressure, abort-by-reset and back-to-back steps.
module tb_fp16_mul_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] a = 16'h0000;
   logic [15:0] b = 16'h0000;
   logic        in_ready, out_valid, busy;
   logic [15:0] y;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          hs_cyc = 0;
   logic [15:0] q[$];

   logic [15:0] ba [4] = '{16'h3C00, 16'h7C00, 16'hC000, 16'h0001};
   logic [15:0] bb [4] = '{16'h3C00, 16'h0000, 16'h3800, 16'h3E00};
   logic [15:0] be [4] = '{16'h3C00, 16'h7E00, 16'hBC00, 16'h0002};

   fp16_mul_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Scoreboard side: every result handshake pops one expected product.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         hs_cyc <= cyc + 1;
         checks++;
         assert (q.size() != 0) else begin
            failures++;
            $error("FAIL unexpected_result: observed=%h expected=none", y);
         end
         if (q.size() != 0) check("result", y, q.pop_front());
      end
   end

   task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_in, input logic [15:0] ex,
                        input int lat_exp, input int hold);
      int lat;
      a        = ta;
      b        = tb_in;
      in_valid = 1'b1;
      out_ready = 1'b0;
      check("in_ready_idle", 16'(in_ready), 16'd1);
      step;
      q.push_back(ex);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         step;
         lat++;
      end
      check("latency", 16'(lat), 16'(lat_exp));
      for (int i = 0; i < hold; i++) begin
         check("hold_out_valid", 16'(out_valid), 16'd1);
         check("hold_y", y, ex);
         check("hold_in_ready", 16'(in_ready), 16'd0);
         a        = 16'h4000;
         b        = 16'h4000;
         in_valid = 1'b1;
         step;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step;
      out_ready = 1'b0;
      check("post_hs_out_valid", 16'(out_valid), 16'd0);
      check("post_hs_y_kept", y, ex);
   endtask

   initial begin
      int t;
      int acc_cyc;
      #1;
      check("rst_out_valid", 16'(out_valid), 16'd0);
      check("rst_in_ready", 16'(in_ready), 16'd1);
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_y", y, 16'h0000);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      step;

      do_op(16'h3C00, 16'h3C00, 16'h3C00, 13, 0);
      do_op(16'h4000, 16'h4200, 16'h4600, 13, 0);
      do_op(16'hC000, 16'h3800, 16'hBC00, 13, 0);
      do_op(16'h7BFF, 16'h4000, 16'h7C00, 13, 0);
      do_op(16'h7C00, 16'h0000, 16'h7E00, 1, 0);
      do_op(16'h0001, 16'h3800, 16'h0000, 13, 0);
      do_op(16'h0001, 16'h3E00, 16'h0002, 13, 0);
      do_op(16'h0400, 16'h3800, 16'h0200, 13, 0);
      do_op(16'hFE01, 16'h3C00, 16'h7E00, 1, 0);
      do_op(16'h7C00, 16'hC000, 16'hFC00, 1, 0);
      do_op(16'h8000, 16'h3C00, 16'h8000, 1, 0);
      do_op(16'h0001, 16'h0001, 16'h0000, 13, 0);
      do_op(16'h3C01, 16'h3C01, 16'h3C02, 13, 0);
      do_op(16'h4200, 16'h4200, 16'h4880, 13, 5);

      // Abort in the middle of MUL.
      a        = 16'h3C00;
      b        = 16'h3C00;
      in_valid = 1'b1;
      step;
      q.push_back(16'h3C00);
      in_valid = 1'b0;
      repeat (6) step;
      check("pre_abort_busy", 16'(busy), 16'd1);
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", 16'(out_valid), 16'd0);
      check("abort_y", y, 16'h0000);
      check("abort_busy", 16'(busy), 16'd0);
      check("abort_in_ready", 16'(in_ready), 16'd1);
      q.delete();
      @(negedge clk) rst_n = 1'b1;
      step;
      do_op(16'h4000, 16'h4000, 16'h4400, 13, 0);

      // Back-to-back with in_valid and out_ready held high.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a         = ba[0];
      b         = bb[0];
      for (int i = 0; i < 4; i++) begin
         t = 0;
         while (!in_ready && t < 60) begin
            step;
            t++;
         end
         check("b2b_accept_wait", 16'(in_ready), 16'd1);
         acc_cyc = cyc + 1;
         step;
         q.push_back(be[i]);
         if (i > 0) check("b2b_gap", 16'(acc_cyc - hs_cyc), 16'd1);
         if (i < 3) begin
            a = ba[i + 1];
            b = bb[i + 1];
         end else begin
            in_valid = 1'b0;
         end
      end
      t = 0;
      while (q.size() != 0 && t < 60) begin
         step;
         t++;
      end
      check("b2b_drain", 16'(q.size()), 16'd0);
      out_ready = 1'b0;
      step;
      check("final_idle", 16'(in_ready), 16'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
